// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and grant encoding for the writeback arbiter
package wb_pkg;
    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    typedef enum logic {GNT_ALU, GNT_MEM} grant_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-input round-robin arbiter, bit 0 = ALU, bit 1 = MEM
import wb_pkg::*;
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    output logic [1:0] ready
);
    grant_t last_q, last_d;
    // grant the lone requester, or the one not served last when both ask
    always_comb begin
        ready[0] = valid[0] & (~valid[1] | (last_q == GNT_MEM));
        ready[1] = valid[1] & (~valid[0] | (last_q == GNT_ALU));
        last_d   = ready[0] ? GNT_ALU : ready[1] ? GNT_MEM : last_q;
    end
    // last-grant moves only when a transfer happens
    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_q <= GNT_ALU;
        else       last_q <= last_d;
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: arbitrates ALU/load writebacks into the register file and tracks pending writes
import wb_pkg::*;
module wb_arbiter (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_data,
    output logic                  mem_ready,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    input  logic [REG_ADDR_W-1:0] chk_rs1,
    input  logic [REG_ADDR_W-1:0] chk_rs2,
    output logic                  hazard,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] w_reg,
    output logic [XLEN-1:0]       w_data
);
    logic [1:0]            ready;
    logic [REG_ADDR_W-1:0] xfer_rd;
    logic [XLEN-1:0]       xfer_data;
    logic                  reg_write_q, reg_write_d;
    logic [REG_ADDR_W-1:0] w_reg_q, w_reg_d;
    logic [XLEN-1:0]       w_data_q, w_data_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .valid ({mem_valid & ~reset, alu_valid & ~reset}),
        .ready (ready)
    );

    assign alu_ready = ready[0];
    assign mem_ready = ready[1];
    assign reg_write = reg_write_q;
    assign w_reg     = w_reg_q;
    assign w_data    = w_data_q;
    assign busy      = busy_q;

    // select the granted writeback, update the scoreboard (set beats clear), check sources
    always_comb begin
        xfer_rd     = ready[1] ? mem_rd : alu_rd;
        xfer_data   = ready[1] ? mem_data : alu_data;
        reg_write_d = (|ready) & (xfer_rd != '0);
        w_reg_d     = reg_write_d ? xfer_rd : w_reg_q;
        w_data_d    = reg_write_d ? xfer_data : w_data_q;
        busy_d      = busy_q;
        if (reg_write_q) busy_d[w_reg_q] = 1'b0;
        if (iss_valid) busy_d[iss_rd] = 1'b1;
        busy_d[0]   = 1'b0;
        hazard      = ((chk_rs1 != '0) & busy_q[chk_rs1]) | ((chk_rs2 != '0) & busy_q[chk_rs2]);
    end

    // write port and scoreboard registers; reset drops any pending write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write_q <= 1'b0;
            w_reg_q     <= '0;
            w_data_q    <= '0;
            busy_q      <= '0;
        end else begin
            reg_write_q <= reg_write_d;
            w_reg_q     <= w_reg_d;
            w_data_q    <= w_data_d;
            busy_q      <= busy_d;
        end
    end
endmodule
